// File: rtl/one_to_four_demultiplexer_pkg.sv
// ---------------------------------------------------------------------------
// one_to_four_demultiplexer_pkg : shared channel encoding and defaults
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package one_to_four_demultiplexer_pkg;

  localparam int NUM_CH        = 4;
  localparam int DEFAULT_WIDTH = 8;

  // Same encoding as the 4:1 select mux.
  localparam logic [1:0] CH_A = 2'd0;
  localparam logic [1:0] CH_B = 2'd1;
  localparam logic [1:0] CH_C = 2'd2;
  localparam logic [1:0] CH_D = 2'd3;

  typedef logic [1:0] sel_t;

endpackage

`default_nettype wire

// File: rtl/one_to_four_demultiplexer_channel.sv
// ---------------------------------------------------------------------------
// demux_channel_reg : one-entry holding register with valid/ready drain
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module demux_channel_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // A write in the same cycle as a drain keeps the entry full.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (valid_q && rd_ready) begin
      valid_d = 1'b0;
    end
    if (wr_en) begin
      valid_d = 1'b1;
      data_d  = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

`default_nettype wire

// File: rtl/one_to_four_demultiplexer.sv
// ---------------------------------------------------------------------------
// one_to_four_demultiplexer : registered 1:4 demux, manual or round-robin
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module one_to_four_demultiplexer
  import one_to_four_demultiplexer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              s0,
  input  logic              s1,
  input  logic              auto_mode,
  output logic [WIDTH-1:0]  out_a,
  output logic [WIDTH-1:0]  out_b,
  output logic [WIDTH-1:0]  out_c,
  output logic [WIDTH-1:0]  out_d,
  output logic [NUM_CH-1:0] out_valid,
  input  logic [NUM_CH-1:0] out_ready,
  output logic [1:0]        cur_sel
);

  sel_t              rr_ptr_q, rr_ptr_d;
  sel_t              sel;
  logic              accept;
  logic [NUM_CH-1:0] wr_en;
  logic [WIDTH-1:0]  ch_data [NUM_CH];

  assign sel      = auto_mode ? rr_ptr_q : {s1, s0};
  assign cur_sel  = sel;
  // Depends only on stored state and consumer ready, never on in_valid.
  assign in_ready = !out_valid[sel] || out_ready[sel];
  assign accept   = in_valid && in_ready;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept && auto_mode) begin
      rr_ptr_d = rr_ptr_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= CH_A;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr_en[i] = accept && (sel == 2'(i));

    demux_channel_reg #(
      .WIDTH (WIDTH)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en[i]),
      .wr_data  (in_data),
      .rd_ready (out_ready[i]),
      .valid    (out_valid[i]),
      .data     (ch_data[i])
    );
  end

  assign out_a = ch_data[CH_A];
  assign out_b = ch_data[CH_B];
  assign out_c = ch_data[CH_C];
  assign out_d = ch_data[CH_D];

endmodule

`default_nettype wire

// File: tb/tb_one_to_four_demultiplexer.sv
// ---------------------------------------------------------------------------
// tb_one_to_four_demultiplexer : directed vector table plus random traffic
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_one_to_four_demultiplexer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       s0 = 1'b0;
  logic       s1 = 1'b0;
  logic       auto_mode = 1'b0;
  logic [7:0] out_a, out_b, out_c, out_d;
  logic [3:0] out_valid;
  logic [3:0] out_ready = '0;
  logic [1:0] cur_sel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  one_to_four_demultiplexer #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s0        (s0),
    .s1        (s1),
    .auto_mode (auto_mode),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_c     (out_c),
    .out_d     (out_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cur_sel   (cur_sel)
  );

  // Reference model: four mailboxes and a pointer that counts accepted words.
  bit         known = 0;
  bit [3:0]   mv;
  logic [7:0] md [4];
  int         mptr;
  logic       got_rdy;
  logic [1:0] got_sel;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic apply(input logic r, input logic [7:0] d, input logic v,
                       input logic [1:0] s, input logic am, input logic [3:0] o);
    int  msel;
    bit  mrdy;
    @(negedge clk);
    rst = r; in_data = d; in_valid = v; {s1, s0} = s; auto_mode = am; out_ready = o;
    #1;
    msel = am ? mptr : int'(s);
    mrdy = !mv[msel] || o[msel];
    got_rdy = in_ready;
    got_sel = cur_sel;
    if (known) begin
      check("model cur_sel", 32'(cur_sel), 32'(msel));
      check("model in_ready", 32'(in_ready), 32'(mrdy));
    end
    @(posedge clk);
    #1;
    if (r) begin
      mv = '0;
      for (int i = 0; i < 4; i++) md[i] = '0;
      mptr = 0;
      known = 1;
    end else if (known) begin
      for (int i = 0; i < 4; i++) if (mv[i] && o[i]) mv[i] = 1'b0;
      if (v && mrdy) begin
        mv[msel] = 1'b1;
        md[msel] = d;
        if (am) mptr = (mptr + 1) % 4;
      end
    end
    if (known) begin
      check("model out_valid", 32'(out_valid), 32'(mv));
      check("model data", {out_d, out_c, out_b, out_a}, {md[3], md[2], md[1], md[0]});
    end
  endtask

  typedef struct {
    logic       r;
    logic [7:0] d;
    logic       v;
    logic [1:0] s;
    logic       am;
    logic [3:0] o;
    logic       exp_rdy;
    logic [1:0] exp_sel;
    logic [3:0] exp_ov;
    logic [31:0] exp_dat;  // {d,c,b,a} after the edge
  } vec_t;

  function automatic vec_t mk(logic r, logic [7:0] d, logic v, logic [1:0] s, logic am,
                              logic [3:0] o, logic er, logic [1:0] es, logic [3:0] eov,
                              logic [31:0] ed);
    vec_t t;
    t.r = r; t.d = d; t.v = v; t.s = s; t.am = am; t.o = o;
    t.exp_rdy = er; t.exp_sel = es; t.exp_ov = eov; t.exp_dat = ed;
    return t;
  endfunction

  vec_t vecs [26];

  initial begin
    // manual routing a,b,c,d
    vecs[0]  = mk(0, 8'h11, 1, 2'd0, 0, 4'hF,    1, 2'd0, 4'b0001, 32'h00000011);
    vecs[1]  = mk(0, 8'h22, 1, 2'd1, 0, 4'hF,    1, 2'd1, 4'b0010, 32'h00002211);
    vecs[2]  = mk(0, 8'h33, 1, 2'd2, 0, 4'hF,    1, 2'd2, 4'b0100, 32'h00332211);
    vecs[3]  = mk(0, 8'h44, 1, 2'd3, 0, 4'hF,    1, 2'd3, 4'b1000, 32'h44332211);
    vecs[4]  = mk(0, 8'h00, 0, 2'd0, 0, 4'hF,    1, 2'd0, 4'b0000, 32'h44332211);
    // round-robin wrap
    vecs[5]  = mk(0, 8'h01, 1, 2'd0, 1, 4'hF,    1, 2'd0, 4'b0001, 32'h44332201);
    vecs[6]  = mk(0, 8'h02, 1, 2'd0, 1, 4'hF,    1, 2'd1, 4'b0010, 32'h44330201);
    vecs[7]  = mk(0, 8'h03, 1, 2'd0, 1, 4'hF,    1, 2'd2, 4'b0100, 32'h44030201);
    vecs[8]  = mk(0, 8'h04, 1, 2'd0, 1, 4'hF,    1, 2'd3, 4'b1000, 32'h04030201);
    vecs[9]  = mk(0, 8'h05, 1, 2'd0, 1, 4'hF,    1, 2'd0, 4'b0001, 32'h04030205);
    vecs[10] = mk(0, 8'h06, 1, 2'd0, 1, 4'hF,    1, 2'd1, 4'b0010, 32'h04030605);
    // fill c manually, then round-robin stalls on c at pointer 2
    vecs[11] = mk(0, 8'h07, 1, 2'd2, 0, 4'b1011, 1, 2'd2, 4'b0100, 32'h04070605);
    vecs[12] = mk(0, 8'h08, 1, 2'd0, 1, 4'b1011, 0, 2'd2, 4'b0100, 32'h04070605);
    vecs[13] = mk(0, 8'h08, 1, 2'd0, 1, 4'b1011, 0, 2'd2, 4'b0100, 32'h04070605);
    vecs[14] = mk(0, 8'h08, 1, 2'd0, 1, 4'hF,    1, 2'd2, 4'b0100, 32'h04080605);
    vecs[15] = mk(0, 8'h00, 0, 2'd0, 1, 4'hF,    1, 2'd3, 4'b0000, 32'h04080605);
    // simultaneous drain and write on d
    vecs[16] = mk(0, 8'h5A, 1, 2'd3, 0, 4'b0111, 1, 2'd3, 4'b1000, 32'h5A080605);
    vecs[17] = mk(0, 8'hA5, 1, 2'd3, 0, 4'hF,    1, 2'd3, 4'b1000, 32'hA5080605);
    // backpressure isolation on b
    vecs[18] = mk(0, 8'hAA, 1, 2'd1, 0, 4'b1101, 1, 2'd1, 4'b0010, 32'hA508AA05);
    vecs[19] = mk(0, 8'hBB, 1, 2'd1, 0, 4'b1101, 0, 2'd1, 4'b0010, 32'hA508AA05);
    vecs[20] = mk(0, 8'hCC, 1, 2'd2, 0, 4'b1101, 1, 2'd2, 4'b0110, 32'hA5CCAA05);
    vecs[21] = mk(0, 8'hBB, 1, 2'd1, 0, 4'hF,    1, 2'd1, 4'b0010, 32'hA5CCBB05);
    // a and c full with pointer at 3, then reset
    vecs[22] = mk(0, 8'h12, 1, 2'd0, 0, 4'h0,    1, 2'd0, 4'b0011, 32'hA5CCBB12);
    vecs[23] = mk(0, 8'h34, 1, 2'd2, 0, 4'h0,    1, 2'd2, 4'b0111, 32'hA534BB12);
    vecs[24] = mk(1, 8'h56, 1, 2'd0, 1, 4'hF,    1, 2'd3, 4'b0000, 32'h00000000);
    vecs[25] = mk(0, 8'h00, 0, 2'd0, 1, 4'h0,    1, 2'd0, 4'b0000, 32'h00000000);

    mv = '0;
    mptr = 0;
    for (int i = 0; i < 4; i++) md[i] = '0;

    apply(1, 8'h00, 0, 2'd0, 0, 4'h0);
    apply(1, 8'h00, 0, 2'd0, 0, 4'h0);
    check("reset out_valid", 32'(out_valid), 32'h0);
    check("reset data", {out_d, out_c, out_b, out_a}, 32'h0);
    @(negedge clk);
    rst = 0; auto_mode = 1; {s1, s0} = 2'd3; in_valid = 0; out_ready = '0;
    #1;
    check("reset cur_sel", 32'(cur_sel), 32'h0);
    check("reset in_ready", 32'(in_ready), 32'h1);

    for (int i = 0; i < 26; i++) begin
      apply(vecs[i].r, vecs[i].d, vecs[i].v, vecs[i].s, vecs[i].am, vecs[i].o);
      check($sformatf("vec%0d in_ready", i), 32'(got_rdy), 32'(vecs[i].exp_rdy));
      check($sformatf("vec%0d cur_sel", i), 32'(got_sel), 32'(vecs[i].exp_sel));
      check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
      check($sformatf("vec%0d data", i), {out_d, out_c, out_b, out_a}, vecs[i].exp_dat);
    end

    for (int n = 0; n < 600; n++) begin
      apply(($urandom_range(0, 40) == 0), 8'($urandom), 1'($urandom),
            2'($urandom), 1'($urandom), 4'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
